nco_phase_gen: RTL

//  Phase-accumulator NCO front end for the downconverter's LO path.

---
 rtl/nco_phase_gen_pkg.sv | 19 +
 rtl/nco_phase_gen_if.sv | 15 +
 rtl/nco_phase_gen_lfsr.sv | 27 ++
 rtl/nco_phase_gen.sv | 89 ++++++++
 4 files changed

// File: rtl/nco_phase_gen_pkg.sv
// Shared widths, typedefs and LFSR constants for the NCO phase generator.
package nco_pkg;

  localparam int unsigned ACC_W_DEF    = 32;
  localparam int unsigned ADDR_W_DEF   = 12;
  localparam int unsigned DITHER_W_DEF = 8;

  typedef logic [ACC_W_DEF-1:0]  phase_t;
  typedef logic [ADDR_W_DEF-1:0] addr_t;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  // Taps 16,14,13,11 expressed as bit positions 15,13,12,10
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  function automatic int unsigned quarter(input int unsigned addr_w);
    return 32'd1 << (addr_w - 2);
  endfunction

endpackage

// File: rtl/nco_phase_gen_if.sv
// Tuning-word valid/ready channel into the NCO phase generator.
interface nco_phase_gen_if
  import nco_pkg::*;
#(
  parameter int unsigned ACC_W = ACC_W_DEF
) ();

  logic [ACC_W-1:0] ftw_data;
  logic             ftw_valid;
  logic             ftw_ready;

  modport master (output ftw_data, output ftw_valid, input ftw_ready);
  modport slave  (input ftw_data, input ftw_valid, output ftw_ready);

endinterface

// File: rtl/nco_phase_gen_lfsr.sv
// 16-bit Fibonacci LFSR dither source; only built when NCO_DITHER_EN is defined.
`ifdef NCO_DITHER_EN
module nco_lfsr
  import nco_pkg::*;
#(
  parameter int unsigned OUT_W = DITHER_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ce,
  output logic [OUT_W-1:0] dither
);

  logic [15:0] state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= LFSR_SEED;
    end else if (ce) begin
      state <= {state[14:0], ^(state & LFSR_TAPS)};
    end
  end

  assign dither = state[OUT_W-1:0];

endmodule
`endif

// File: rtl/nco_phase_gen.sv
// Phase-accumulator NCO front end producing cos/sin ROM addresses and valid strobes.
// Define NCO_DITHER_EN to add LFSR dither below the truncation point.
module nco_phase_gen
  import nco_pkg::*;
#(
  parameter int unsigned ACC_W    = ACC_W_DEF,
  parameter int unsigned ADDR_W   = ADDR_W_DEF,
  parameter int unsigned DITHER_W = DITHER_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ce,
  nco_phase_gen_if.slave    ftw,
  input  logic [ADDR_W-1:0] phase_ofs,
  input  logic              sync_clr,
  output logic [ADDR_W-1:0] cos_addr,
  output logic [ADDR_W-1:0] sin_addr,
  output logic              addr_valid,
  output logic              data_valid
);

  localparam logic [ADDR_W-1:0] QUARTER = ADDR_W'(quarter(ADDR_W));

  logic [ACC_W-1:0]    acc;
  logic [ACC_W-1:0]    ftw_act;
  logic [ACC_W-1:0]    ftw_pend;
  logic                pend;
  logic                take;
  logic [DITHER_W-1:0] dither_lsb;
  logic [ACC_W-1:0]    phase_sum;
  logic [ADDR_W-1:0]   cos_next;

`ifdef NCO_DITHER_EN
  nco_lfsr #(
    .OUT_W (DITHER_W)
  ) u_lfsr (
    .clk    (clk),
    .rst    (rst),
    .ce     (ce),
    .dither (dither_lsb)
  );
`else
  assign dither_lsb = '0;
`endif

  assign ftw.ftw_ready = ~pend & ~rst;
  assign take          = ftw.ftw_valid & ftw.ftw_ready;

  // Address comes from the pre-increment accumulator, offset in table LSBs
  always_comb begin
    phase_sum = acc + {phase_ofs, {(ACC_W-ADDR_W){1'b0}}} + ACC_W'(dither_lsb);
    cos_next  = phase_sum[ACC_W-1 -: ADDR_W];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc        <= '0;
      ftw_act    <= '0;
      ftw_pend   <= '0;
      pend       <= 1'b0;
      cos_addr   <= '0;
      sin_addr   <= '0;
      addr_valid <= 1'b0;
      data_valid <= 1'b0;
    end else begin
      // Apply and capture cannot collide: ready is low whenever pend is set
      if (ce && pend) begin
        ftw_act <= ftw_pend;
        pend    <= 1'b0;
      end
      if (take) begin
        ftw_pend <= ftw.ftw_data;
        pend     <= 1'b1;
      end
      if (sync_clr) begin
        acc <= '0;
      end else if (ce) begin
        acc <= acc + ftw_act;
      end
      if (ce) begin
        cos_addr <= cos_next;
        sin_addr <= cos_next - QUARTER;
      end
      addr_valid <= ce;
      data_valid <= addr_valid;
    end
  end

endmodule
